qm_icache: RTL and testbench
============================

QM_ICACHE -- requirements
Module: qm_icache

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 4, meaning log2 of line count (16 lines).
REQ-002 The block SHALL have parameter LINE_WORDS fixed at 4 32-bit words per line (16 bytes); not overridable.
REQ-003 Port sys_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port sys_rst_n, input, 1: synchronous active-low reset, sampled on sys_clk rising edge.
REQ-005 Port enable, input, 1: fetch stage is requesting an instruction at address.
REQ-006 Port address, input, 32: fetch byte address; bits [1:0] ignored.
REQ-007 Port invalidate, input, 1: clear all valid bits.
REQ-008 Port hit, output, 1: word at address is present and valid.
REQ-009 Port should_stall, output, 1: fetch must hold its PC this cycle.
REQ-010 Port data, output, 32: instruction word at address when hit=1.
REQ-011 Port mem_req, output, 1: refill beat request to backing memory.
REQ-012 Port mem_addr, output, 32: word-aligned byte address of the requested beat.
REQ-013 Port mem_ack, input, 1: mem_data is valid for the current beat; at most one beat per cycle.
REQ-014 Port mem_data, input, 32: refill word.

Function
REQ-015 Address split SHALL be: [3:2] word offset, [INDEX_BITS+3:4] index, [31:INDEX_BITS+4] tag (24 bits at default).
REQ-016 Storage SHALL be direct-mapped: per line one valid bit, one tag, LINE_WORDS data words.
REQ-017 hit SHALL be combinational: valid[index] and tag[index] equals address tag; independent of enable and state.
REQ-018 data SHALL be combinational: the stored word at [index][word offset]; value is don't-care when hit=0.
REQ-019 should_stall SHALL equal enable and not hit, combinationally, in every state.
REQ-020 FSM states SHALL be IDLE and FILL.
REQ-021 IDLE: if enable=1 and hit=0, the block SHALL latch address[31:4] as fill base, clear valid[fill index], clear beat counter to 0, clear the abort flag, and enter FILL next cycle.
REQ-022 FILL: mem_req SHALL be 1 and mem_addr SHALL be {fill base, beat[1:0], 2'b00}; mem_req is 0 and mem_addr is 0 in IDLE.
REQ-023 On each FILL cycle with mem_ack=1, mem_data SHALL be written to [fill index][beat] and beat SHALL increment by 1.
REQ-024 On the ack of beat 3, the block SHALL write tag[fill index], set valid[fill index] unless the abort flag is set or invalidate is 1 that cycle, and return to IDLE.
REQ-025 The first hit on the filled line SHALL be the cycle after the beat-3 ack (miss-to-hit latency = 1 + 4 beats + memory wait cycles).
REQ-026 Address changes during FILL SHALL NOT affect the latched fill; hit continues to be evaluated against current address and other valid lines.
REQ-027 invalidate=1 in any state SHALL clear all valid bits at the next edge; in FILL it SHALL also set the abort flag, and the fill SHALL still complete all 4 beats.
REQ-028 invalidate=1 and a miss in IDLE in the same cycle SHALL clear all valid bits and start the fill normally.
REQ-029 mem_ack in IDLE SHALL be ignored.

Reset
REQ-030 While sys_rst_n=0 at an edge: state SHALL go IDLE, all valid bits 0, beat 0, abort flag 0; tags and data are not reset.
REQ-031 After reset: hit=0, should_stall=enable, mem_req=0, mem_addr=0.
REQ-032 Reset mid-FILL SHALL abandon the burst; the partially filled line remains invalid; the memory side tolerates dropped mem_req.

Verification
REQ-033 Cold miss: reset, enable=1, address=0x0000_1004, mem_ack=1 every cycle with data 0xA0..0xA3 -> should_stall=1 for 5 cycles, mem_addr 0x1000,0x1004,0x1008,0x100C, then hit=1, data=0xA1.
REQ-034 Same-line hits after fill: addresses 0x1000,0x1008,0x100C -> hit=1 each cycle, data 0xA0,0xA2,0xA3, mem_req=0.
REQ-035 Conflict: fill 0x1000 then access 0x2000 (same index 0, different tag) -> miss, refill, 0x1000 subsequently misses.
REQ-036 Memory wait states: mem_ack pattern 0,1,0,0,1,1,0,1 -> exactly 4 writes in beat order, mem_addr held stable during ack=0 cycles.
REQ-037 Invalidate during FILL at beat 2 -> fill completes 4 beats, line not valid, next access to same address misses again.
REQ-038 Reset asserted after beat 1 ack -> mem_req=0 next cycle, hit=0 for that address, new fill restarts at beat 0.

Source files
------------

// File: rtl/qm_icache.sv
// qm_icache: direct-mapped instruction cache with 4-word lines.
// Misses are refilled one beat at a time from backing memory.
module qm_icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic [31:0] address,
    input  logic        invalidate,
    output logic        hit,
    output logic        should_stall,
    output logic [31:0] data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
);
    localparam int LINE_WORDS = 4;
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;
    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_next;
    logic [LINES-1:0] valid;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [31:0] words [LINES*LINE_WORDS];
    logic [27:0] fill_base;
    logic [1:0] beat;
    logic abort;
    logic [INDEX_BITS-1:0] idx, fill_idx;
    logic [TAG_BITS-1:0] tag;
    logic unused_offset;
    assign idx = address[INDEX_BITS+3:4];
    assign tag = address[31:INDEX_BITS+4];
    assign fill_idx = fill_base[INDEX_BITS-1:0];
    assign unused_offset = ^address[1:0];
    assign hit = valid[idx] && tags[idx] == tag;
    assign data = words[{idx, address[3:2]}];
    assign should_stall = enable && !hit;
    assign mem_req = state == FILL;
    assign mem_addr = mem_req ? {fill_base, beat, 2'b00} : '0;
    always_comb begin
        state_next = state;
        if (state == IDLE && should_stall) state_next = FILL;
        if (state == FILL && mem_ack && beat == 2'd3) state_next = IDLE;
    end
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            valid <= '0;
            beat <= '0;
            abort <= 1'b0;
        end else begin
            state <= state_next;
            if (invalidate) valid <= '0;
            if (state == IDLE && should_stall) begin
                valid[idx] <= 1'b0;
                beat <= '0;
                abort <= 1'b0;
            end
            if (state == FILL) begin
                if (invalidate) abort <= 1'b1;
                if (mem_ack) beat <= beat + 2'd1;
                // a flush seen at any point of the burst leaves the line invalid
                if (mem_ack && beat == 2'd3 && !abort && !invalidate) valid[fill_idx] <= 1'b1;
            end
        end
    end
    always_ff @(posedge sys_clk) begin
        if (state == IDLE && should_stall) fill_base <= address[31:4];
        if (state == FILL && mem_ack) words[{fill_idx, beat}] <= mem_data;
        if (state == FILL && mem_ack && beat == 2'd3) tags[fill_idx] <= fill_base[27:INDEX_BITS];
    end
endmodule

// File: tb/tb_qm_icache.sv
// tb_qm_icache: directed scoreboard bench for qm_icache.
module tb_qm_icache;
    logic sys_clk = 1'b0, sys_rst_n = 1'b0, enable = 1'b0, invalidate = 1'b0, mem_ack = 1'b0;
    logic [31:0] address = '0, data_base = '0;
    logic hit, should_stall, mem_req;
    logic [31:0] data, mem_addr, mem_data;
    logic done = 1'b0;
    int checks = 0, fails = 0;
    typedef struct {
        string name;
        logic hit;
        logic stall;
        logic req;
        logic [31:0] addr;
    } st_t;
    st_t st_q[$];
    logic [31:0] beat_q[$];
    logic [31:0] data_q[$];
    // backing memory returns data_base plus the beat number
    assign mem_data = data_base + {30'h0, mem_addr[3:2]};
    always #5 sys_clk = ~sys_clk;
    qm_icache dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .address(address),
        .invalidate(invalidate), .hit(hit), .should_stall(should_stall), .data(data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
    );
    task automatic step(input string n, input logic en, input logic [31:0] a, input logic inv,
                        input logic ack, input logic eh, input logic es, input logic er,
                        input logic [31:0] ea);
        st_t e;
        @(posedge sys_clk);
        #1;
        enable = en;
        address = a;
        invalidate = inv;
        mem_ack = ack;
        e.name = n;
        e.hit = eh;
        e.stall = es;
        e.req = er;
        e.addr = ea;
        st_q.push_back(e);
    endtask
    task automatic beat(input string n, input logic [31:0] a, input logic inv, input logic [31:0] ma);
        step(n, 1'b1, a, inv, 1'b1, 1'b0, 1'b1, 1'b1, ma);
        beat_q.push_back(ma);
    endtask
    task automatic fill(input string n, input logic [31:0] a);
        for (int k = 0; k < 4; k++) beat(n, a, 1'b0, {a[31:4], 4'h0} + 32'(4 * k));
    endtask
    task automatic hit_at(input string n, input logic [31:0] a, input logic [31:0] d);
        step(n, 1'b1, a, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        data_q.push_back(d);
    endtask
    always @(negedge sys_clk) begin : mon
        st_t e;
        logic [31:0] x;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            checks++;
            if ({hit, should_stall, mem_req, mem_addr} !== {e.hit, e.stall, e.req, e.addr}) begin
                fails++;
                $display("FAIL %s: hit/stall/req/addr got %b/%b/%b/%h expected %b/%b/%b/%h",
                         e.name, hit, should_stall, mem_req, mem_addr, e.hit, e.stall, e.req, e.addr);
            end
        end
        if (mem_req && mem_ack) begin
            checks++;
            if (beat_q.size() == 0) begin
                fails++;
                $display("FAIL beat: unexpected beat at %h expected none", mem_addr);
            end else begin
                x = beat_q.pop_front();
                if (mem_addr !== x) begin
                    fails++;
                    $display("FAIL beat: mem_addr got %h expected %h", mem_addr, x);
                end
            end
        end
        if (enable && hit) begin
            checks++;
            if (data_q.size() == 0) begin
                fails++;
                $display("FAIL fetch: unexpected hit at %h data %h", address, data);
            end else begin
                x = data_q.pop_front();
                if (data !== x) begin
                    fails++;
                    $display("FAIL fetch: data at %h got %h expected %h", address, data, x);
                end
            end
        end
        if (done) begin
            checks++;
            if (st_q.size() + beat_q.size() + data_q.size() != 0) begin
                fails++;
                $display("FAIL drain: %0d/%0d/%0d items left expected 0/0/0",
                         st_q.size(), beat_q.size(), data_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
            $finish;
        end
    end
    initial begin
        step("reset", 1, 32'h1004, 0, 0, 0, 1, 0, 32'h0);
        step("cold idle", 1, 32'h1004, 0, 1, 0, 1, 0, 32'h0);
        sys_rst_n = 1'b1;
        data_base = 32'hA0;
        fill("cold fill", 32'h1004);
        hit_at("cold hit", 32'h1004, 32'hA1);
        hit_at("line hit 0", 32'h1000, 32'hA0);
        hit_at("line hit 2", 32'h1008, 32'hA2);
        hit_at("line hit 3", 32'h100C, 32'hA3);
        step("conflict miss", 1, 32'h2000, 0, 1, 0, 1, 0, 32'h0);
        data_base = 32'hB0;
        fill("conflict fill", 32'h2000);
        hit_at("conflict hit", 32'h2000, 32'hB0);
        step("evicted miss", 1, 32'h1000, 0, 0, 0, 1, 0, 32'h0);
        data_base = 32'hA0;
        step("wait 0", 1, 32'h1000, 0, 0, 0, 1, 1, 32'h1000);
        beat("wait ack 0", 32'h1000, 0, 32'h1000);
        step("wait addr move", 1, 32'h3040, 0, 0, 0, 1, 1, 32'h1004);
        step("wait hold", 1, 32'h3040, 0, 0, 0, 1, 1, 32'h1004);
        beat("wait ack 1", 32'h3040, 0, 32'h1004);
        beat("wait ack 2", 32'h3040, 0, 32'h1008);
        step("wait 3", 1, 32'h3040, 0, 0, 0, 1, 1, 32'h100C);
        beat("wait ack 3", 32'h3040, 0, 32'h100C);
        hit_at("wait hit", 32'h1008, 32'hA2);
        step("displaced", 0, 32'h2000, 0, 0, 0, 0, 0, 32'h0);
        step("inv miss", 1, 32'h4020, 0, 1, 0, 1, 0, 32'h0);
        data_base = 32'hC0;
        beat("inv fill 0", 32'h4020, 0, 32'h4020);
        beat("inv fill 1", 32'h4020, 0, 32'h4024);
        beat("inv at beat 2", 32'h4020, 1, 32'h4028);
        beat("inv fill 3", 32'h4020, 0, 32'h402C);
        step("inv flushed", 0, 32'h1008, 0, 0, 0, 0, 0, 32'h0);
        step("inv remiss", 1, 32'h4020, 0, 0, 0, 1, 0, 32'h0);
        data_base = 32'hD0;
        beat("rst fill 0", 32'h4020, 0, 32'h4020);
        beat("rst fill 1", 32'h4020, 0, 32'h4024);
        step("rst edge", 1, 32'h4020, 0, 0, 0, 1, 1, 32'h4028);
        sys_rst_n = 1'b0;
        step("post rst", 1, 32'h4020, 0, 0, 0, 1, 0, 32'h0);
        sys_rst_n = 1'b1;
        fill("refill", 32'h4020);
        hit_at("refill hit", 32'h4024, 32'hD1);
        step("inv idle miss", 1, 32'h1000, 1, 0, 0, 1, 0, 32'h0);
        data_base = 32'hE0;
        fill("inv idle fill", 32'h1000);
        hit_at("inv idle hit", 32'h1004, 32'hE1);
        step("inv idle flushed", 0, 32'h4020, 0, 0, 0, 0, 0, 32'h0);
        step("end", 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        done = 1'b1;
    end
endmodule
